// File: rtl/msgmii_clk_monitor_if.sv
// ---------------------------------------------------------------------------
// msgmii_clk_monitor_if
// Bundles the per-domain clock/reset observation inputs and the supervisor
// status outputs of msgmii_clk_monitor.
//   dom_tgl   : per-domain free-running toggle (async to the system clock)
//   dom_rst   : per-domain synchronised reset, active-high (async)
//   clr_fault : single-cycle pulse clearing the sticky fault flag
//   reset_req : request into the domain reset generators, active-high
//   clk_ok    : per-domain clock-alive flags
//   all_ready : every clock alive and every domain reset released
//   fault     : sticky fault flag
//   fault_cnt : saturating count of fault events
// modport slave  : the monitor (consumes observations, drives status)
// modport master : the environment (drives observations, reads status)
// ---------------------------------------------------------------------------
interface msgmii_clk_monitor_if #(
   parameter int N_DOM = 5
);
   logic [N_DOM-1:0] dom_tgl;
   logic [N_DOM-1:0] dom_rst;
   logic             clr_fault;
   logic             reset_req;
   logic [N_DOM-1:0] clk_ok;
   logic             all_ready;
   logic             fault;
   logic [7:0]       fault_cnt;

   modport master (
      output dom_tgl, dom_rst, clr_fault,
      input  reset_req, clk_ok, all_ready, fault, fault_cnt
   );

   modport slave (
      input  dom_tgl, dom_rst, clr_fault,
      output reset_req, clk_ok, all_ready, fault, fault_cnt
   );
endinterface

// File: rtl/msgmii_clk_monitor.sv
// ---------------------------------------------------------------------------
// msgmii_clk_monitor
// System-clock-domain supervisor for the MSGMII clock/reset network. Checks
// that every domain clock is alive via its toggle, holds the reset request
// until all clocks run, waits for every domain reset to release, and reports
// a sticky fault (with a saturating event count) on clock loss or an
// unexpected domain reset reassertion, then re-sequences.
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : asynchronous active-high reset
//   mon   : msgmii_clk_monitor_if.slave (dom_tgl, dom_rst, clr_fault in;
//           reset_req, clk_ok, all_ready, fault, fault_cnt out)
// ---------------------------------------------------------------------------
module msgmii_clk_monitor #(
   parameter int N_DOM    = 5,
   parameter int TIMEOUT  = 64,
   parameter int CNT_W    = 7,
   parameter int HOLD_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   msgmii_clk_monitor_if.slave  mon
);

   localparam int               HC_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT);
   localparam logic [HC_W-1:0]  HC_LAST = HC_W'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_READY   = 2'd2,
      ST_FAULT   = 2'd3
   } state_t;

   logic [N_DOM-1:0] tgl_s1_q, tgl_s2_q, tgl_s3_q;
   logic [N_DOM-1:0] rst_s1_q, rst_s2_q;
   logic [N_DOM-1:0] tgl_edge;
   logic [CNT_W-1:0] wd_q [N_DOM];
   logic [CNT_W-1:0] wd_d [N_DOM];
   logic [N_DOM-1:0] clk_ok_q, clk_ok_d;
   state_t           state_q, state_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic             reset_req_q, reset_req_d;
   logic             all_ready_q, all_ready_d;
   logic             fault_q, fault_d;
   logic [7:0]       fault_cnt_q, fault_cnt_d;

   // Two-flop synchronisers; the third toggle flop exposes one edge pulse
   // per domain clock edge regardless of toggle polarity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgl_s1_q <= '0;
         tgl_s2_q <= '0;
         tgl_s3_q <= '0;
         rst_s1_q <= '1;
         rst_s2_q <= '1;
      end else begin
         tgl_s1_q <= mon.dom_tgl;
         tgl_s2_q <= tgl_s1_q;
         tgl_s3_q <= tgl_s2_q;
         rst_s1_q <= mon.dom_rst;
         rst_s2_q <= rst_s1_q;
      end
   end

   assign tgl_edge = tgl_s2_q ^ tgl_s3_q;

   // Watchdogs start saturated so a domain never seen toggling reads as dead.
   always_comb begin
      for (int i = 0; i < N_DOM; i++) begin
         wd_d[i] = wd_q[i];
         if (tgl_edge[i]) begin
            wd_d[i] = '0;
         end else if (wd_q[i] < WD_MAX) begin
            wd_d[i] = wd_q[i] + 1'b1;
         end
         clk_ok_d[i] = (wd_q[i] < WD_MAX);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_DOM; i++) begin
            wd_q[i] <= WD_MAX;
         end
         clk_ok_q <= '0;
      end else begin
         for (int i = 0; i < N_DOM; i++) begin
            wd_q[i] <= wd_d[i];
         end
         clk_ok_q <= clk_ok_d;
      end
   end

   // Sequencer. Outputs are registered from the next state so all_ready and
   // reset_req change in the same cycle as the state itself.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_HOLD: begin
            if (hold_cnt_q == HC_LAST) begin
               if (&clk_ok_q) state_d = ST_RELEASE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            // Every clock was alive on entry, so any zero here is a fall.
            if (!(&clk_ok_q))          state_d = ST_FAULT;
            else if (rst_s2_q == '0)   state_d = ST_READY;
         end
         ST_READY: begin
            // Resets were all low on entry, so any high bit is a rise.
            if (!(&clk_ok_q) || (|rst_s2_q)) state_d = ST_FAULT;
         end
         default: begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
         end
      endcase

      reset_req_d = (state_d == ST_HOLD) || (state_d == ST_FAULT);
      all_ready_d = (state_d == ST_READY);

      // A clear arriving on FAULT entry or during the FAULT cycle loses.
      fault_d = fault_q;
      if (mon.clr_fault) fault_d = 1'b0;
      if ((state_d == ST_FAULT) || (state_q == ST_FAULT)) fault_d = 1'b1;

      fault_cnt_d = fault_cnt_q;
      if ((state_d == ST_FAULT) && (fault_cnt_q != 8'hFF)) begin
         fault_cnt_d = fault_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HOLD;
         hold_cnt_q  <= '0;
         reset_req_q <= 1'b1;
         all_ready_q <= 1'b0;
         fault_q     <= 1'b0;
         fault_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         reset_req_q <= reset_req_d;
         all_ready_q <= all_ready_d;
         fault_q     <= fault_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign mon.reset_req = reset_req_q;
   assign mon.clk_ok    = clk_ok_q;
   assign mon.all_ready = all_ready_q;
   assign mon.fault     = fault_q;
   assign mon.fault_cnt = fault_cnt_q;

endmodule
